// File: rtl/fixed_vector_reduce_acc.sv
// fixed_vector_reduce_acc
// Reduces a stream of signed product vectors to one dot-product value every
// ACC_DEPTH accepted beats. Adder tree is combinational; the running sum and
// the result register are updated only on an accepted beat.
module fixed_vector_reduce_acc #(
  parameter  int IN_WIDTH  = 48,
  parameter  int IN_SIZE   = 4,
  parameter  int ACC_DEPTH = 4,
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE) + $clog2(ACC_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  // Counter is at least one bit wide so ACC_DEPTH==1 still elaborates.
  localparam int             CW   = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ACC_DEPTH - 1);

  logic [CW-1:0]        r_beat_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_data_out;
  logic                 r_data_out_valid;

  logic [OUT_WIDTH-1:0] w_ext [IN_SIZE];
  logic [OUT_WIDTH-1:0] w_vec_sum;
  logic [OUT_WIDTH-1:0] w_group_sum;
  logic                 w_first;
  logic                 w_last;
  logic                 w_accept;

  // Sign-extend every element to the full result width before summing, so
  // the tree and the accumulator can never overflow.
  for (genvar g = 0; g < IN_SIZE; g++) begin : g_ext
    assign w_ext[g] = OUT_WIDTH'(signed'(data_in[g]));
  end

  // Adder tree across the vector elements.
  always_comb begin
    w_vec_sum = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_vec_sum = w_vec_sum + w_ext[i];
    end
  end

  assign w_first     = (r_beat_cnt == '0);
  assign w_last      = (r_beat_cnt == LAST);
  // Beat 0 overwrites the stale accumulator; this also covers ACC_DEPTH==1.
  assign w_group_sum = w_first ? w_vec_sum : (r_acc + w_vec_sum);

  // Only the final beat of a group can collide with an unconsumed result.
  assign data_in_ready = !(w_last && r_data_out_valid && !data_out_ready);
  assign w_accept      = data_in_valid && data_in_ready;

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

  // Beat counter and running accumulator, advanced on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + CW'(1);
      r_acc      <= w_group_sum;
    end
  end

  // Result register: load on the final beat, clear on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_data_out       <= w_group_sum;
      r_data_out_valid <= 1'b1;
    end else if (r_data_out_valid && data_out_ready) begin
      r_data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_vector_reduce_acc.sv
// Directed bench: three instances cover ACC_DEPTH 2, 4 and 1 with 8-bit
// elements so expected values stay hand-checkable.
module tb_fixed_vector_reduce_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // A: IN_WIDTH=8, IN_SIZE=4, ACC_DEPTH=2 -> OUT_WIDTH=11
  logic [7:0]  a_din [3:0];
  logic        a_vld, a_rdy, a_ovld, a_ordy;
  logic [10:0] a_out;
  // B: IN_WIDTH=8, IN_SIZE=4, ACC_DEPTH=4 -> OUT_WIDTH=12
  logic [7:0]  b_din [3:0];
  logic        b_vld, b_rdy, b_ovld, b_ordy;
  logic [11:0] b_out;
  // C: IN_WIDTH=8, IN_SIZE=4, ACC_DEPTH=1 -> OUT_WIDTH=10
  logic [7:0]  c_din [3:0];
  logic        c_vld, c_rdy, c_ovld, c_ordy;
  logic [9:0]  c_out;

  fixed_vector_reduce_acc #(.IN_WIDTH(8), .IN_SIZE(4), .ACC_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_vld),
    .data_in_ready(a_rdy), .data_out(a_out), .data_out_valid(a_ovld),
    .data_out_ready(a_ordy));
  fixed_vector_reduce_acc #(.IN_WIDTH(8), .IN_SIZE(4), .ACC_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_vld),
    .data_in_ready(b_rdy), .data_out(b_out), .data_out_valid(b_ovld),
    .data_out_ready(b_ordy));
  fixed_vector_reduce_acc #(.IN_WIDTH(8), .IN_SIZE(4), .ACC_DEPTH(1)) u_c (
    .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_vld),
    .data_in_ready(c_rdy), .data_out(c_out), .data_out_valid(c_ovld),
    .data_out_ready(c_ordy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    a_din = '{8'd9, 8'd9, 8'd9, 8'd9}; a_vld = 1'b1; a_ordy = 1'b1;
    b_din = '{8'd9, 8'd9, 8'd9, 8'd9}; b_vld = 1'b1; b_ordy = 1'b1;
    c_din = '{8'd9, 8'd9, 8'd9, 8'd9}; c_vld = 1'b1; c_ordy = 1'b1;

    // Reset held 2 cycles with valid inputs: no result may appear.
    tick(); tick();
    chk("rst_a_vld", 32'(a_ovld), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_b_vld", 32'(b_ovld), 32'd0);
    chk("rst_c_vld", 32'(c_ovld), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    tick();
    chk("rst_a_rdy", 32'(a_rdy), 32'd1);
    chk("rst_b_rdy", 32'(b_rdy), 32'd1);
    chk("rst_c_vld2", 32'(c_ovld), 32'd0);

    // Basic group on A: {1,2,3,4} + {5,6,7,8} = 36.
    a_din = '{8'd4, 8'd3, 8'd2, 8'd1}; a_vld = 1'b1;
    tick();
    chk("basic_vld0", 32'(a_ovld), 32'd0);
    a_din = '{8'd8, 8'd7, 8'd6, 8'd5};
    tick();
    chk("basic_vld1", 32'(a_ovld), 32'd1);
    chk("basic_out", 32'(a_out), 32'(11'd36));
    a_vld = 1'b0;
    tick();
    chk("basic_vld_1cyc", 32'(a_ovld), 32'd0);

    // Backpressure on A: beats 1,2,3,4 (element 0 only) -> results 3 then 7.
    a_ordy = 1'b0; a_vld = 1'b1;
    a_din = '{8'd0, 8'd0, 8'd0, 8'd1};
    tick();
    a_din = '{8'd0, 8'd0, 8'd0, 8'd2};
    tick();
    chk("bp_r1_vld", 32'(a_ovld), 32'd1);
    chk("bp_r1_out", 32'(a_out), 32'(11'd3));
    a_din = '{8'd0, 8'd0, 8'd0, 8'd3};
    #1;
    chk("bp_b3_rdy", 32'(a_rdy), 32'd1);
    tick();
    chk("bp_hold_out", 32'(a_out), 32'(11'd3));
    a_din = '{8'd0, 8'd0, 8'd0, 8'd4};
    #1;
    chk("bp_b4_stall", 32'(a_rdy), 32'd0);
    tick();
    chk("bp_hold_vld", 32'(a_ovld), 32'd1);
    chk("bp_hold_out2", 32'(a_out), 32'(11'd3));
    a_ordy = 1'b1;
    #1;
    chk("bp_recover_rdy", 32'(a_rdy), 32'd1);
    tick();
    a_vld = 1'b0;
    chk("bp_r2_vld", 32'(a_ovld), 32'd1);
    chk("bp_r2_out", 32'(a_out), 32'(11'd7));
    tick();
    chk("bp_drained", 32'(a_ovld), 32'd0);

    // Signed extremes on B, two groups back to back without a bubble.
    b_vld = 1'b1; b_din = '{8'h80, 8'h80, 8'h80, 8'h80};
    tick(); tick(); tick();
    chk("ext_neg_vld0", 32'(b_ovld), 32'd0);
    tick();
    chk("ext_neg_vld", 32'(b_ovld), 32'd1);
    chk("ext_neg_out", 32'(b_out), 32'(12'h800));
    b_din = '{8'd127, 8'd127, 8'd127, 8'd127};
    tick();
    chk("ext_gap_vld", 32'(b_ovld), 32'd0);
    tick(); tick(); tick();
    chk("ext_pos_vld", 32'(b_ovld), 32'd1);
    chk("ext_pos_out", 32'(b_out), 32'(12'd2032));
    b_vld = 1'b0;
    tick();

    // Back-to-back on C (ACC_DEPTH=1): 4, 8, -3 on consecutive cycles.
    c_vld = 1'b1; c_din = '{8'd1, 8'd1, 8'd1, 8'd1};
    tick();
    chk("b2b_out0", 32'(c_out), 32'(10'd4));
    chk("b2b_vld0", 32'(c_ovld), 32'd1);
    c_din = '{8'd2, 8'd2, 8'd2, 8'd2};
    tick();
    chk("b2b_out1", 32'(c_out), 32'(10'd8));
    chk("b2b_vld1", 32'(c_ovld), 32'd1);
    c_din = '{8'd0, 8'd0, 8'd0, 8'hFD};
    tick();
    chk("b2b_out2", 32'(c_out), 32'(10'h3FD));
    chk("b2b_vld2", 32'(c_ovld), 32'd1);
    c_vld = 1'b0;
    tick();
    chk("b2b_idle", 32'(c_ovld), 32'd0);

    // Reset mid-group on B: partial sum of 20 must be discarded.
    b_vld = 1'b1; b_din = '{8'd0, 8'd0, 8'd0, 8'd10};
    tick(); tick();
    b_vld = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    b_vld = 1'b1; b_din = '{8'd0, 8'd0, 8'd0, 8'd1};
    tick(); tick(); tick();
    chk("mid_rst_vld0", 32'(b_ovld), 32'd0);
    tick();
    chk("mid_rst_vld", 32'(b_ovld), 32'd1);
    chk("mid_rst_out", 32'(b_out), 32'(12'd4));
    b_vld = 1'b0;
    tick();
    chk("mid_rst_single", 32'(b_ovld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fixed_vector_reduce_acc.md
# fixed_vector_reduce_acc

Consumer end of the element-wise product path: accepts a stream of `IN_SIZE`-element signed product vectors (as emitted by the fixed-point vector multiplier) and reduces them to a single signed dot-product value. Each accepted vector is summed by a combinational adder tree and accumulated over `ACC_DEPTH` consecutive beats. One result is emitted per `ACC_DEPTH` input beats through a registered valid/ready output. It sits between the vector multiplier and the bias/requantise stage in linear-layer datapaths.

## Interface
- `IN_WIDTH`, default 48: width of each product element, two's complement.
- `IN_SIZE`, default 4: elements per input vector, ≥1.
- `ACC_DEPTH`, default 4: beats accumulated per result, ≥1.
- `OUT_WIDTH`, default `IN_WIDTH + $clog2(IN_SIZE) + $clog2(ACC_DEPTH)`: result width, two's complement. Fixed at this value; not overridable to anything smaller.
- `clk`, input, 1: clock. Single clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `data_in`, input, `IN_WIDTH` × `IN_SIZE` (unpacked array `[IN_SIZE-1:0]`): product vector.
- `data_in_valid`, input, 1: input beat valid.
- `data_in_ready`, output, 1: input beat accepted when `data_in_valid && data_in_ready`.
- `data_out`, output, `OUT_WIDTH`: accumulated dot product.
- `data_out_valid`, output, 1: result valid.
- `data_out_ready`, input, 1: downstream accepts the result.

## Operation
- **Adder tree:** `vec_sum` is the sum of all `data_in[i]`. Each element is sign-extended to `OUT_WIDTH` first, so no overflow is possible.
- **Beat counter:** `beat_cnt` runs 0..`ACC_DEPTH-1`. It increments on each accepted beat and wraps to 0 after the last beat of a group.
- **Accumulator:** `acc` is `OUT_WIDTH` wide and updates only on accept.
  - `beat_cnt==0`: `acc <= vec_sum`. This overwrites the old value, so no clear cycle is needed.
  - Otherwise: `acc <= acc + vec_sum`.
- **Output register load:** on an accept with `beat_cnt==ACC_DEPTH-1`, the register loads `data_out <= (ACC_DEPTH==1 ? vec_sum : acc + vec_sum)` and sets `data_out_valid <= 1`.
- **Output register hold and clear:**
  - While `data_out_valid && !data_out_ready`, `data_out` and `data_out_valid` hold unchanged.
  - On `data_out_valid && data_out_ready` with no simultaneous load, `data_out_valid <= 0`.
  - On a simultaneous drain and load, the register takes the new result and `data_out_valid` stays 1.
- **Backpressure:** `data_in_ready = !(beat_cnt==ACC_DEPTH-1 && data_out_valid && !data_out_ready)`.
  - Non-final beats of the next group are accepted while a result is still pending.
  - The input stalls only when the final beat would overwrite an unconsumed result.
  - The combinational path from `data_out_ready` to `data_in_ready` is allowed.
- **Protocol rules:**
  - `data_out` is stable while `data_out_valid` is high and not accepted.
  - `data_in_ready` does not depend on `data_in_valid`.
- **Reset:** reset takes priority over all other activity. On reset:
  - `beat_cnt=0`, `acc=0`, `data_out=0`, `data_out_valid=0`.
  - A partially accumulated group is discarded.
  - A pending unaccepted result is dropped.
- **Degenerate sizes:** `ACC_DEPTH==1` makes every accepted beat produce one result. `IN_SIZE==1` reduces the adder tree to a sign extension.

## Timing
- Reset values:
  - `data_out_valid=0`, `data_out=0`.
  - `data_in_ready=1` in the cycle after reset deasserts (`beat_cnt=0`, output empty).
- **Latency:** `data_out_valid` rises in the cycle after the final beat of a group is accepted, i.e. 1-cycle latency from that beat.
- **Throughput:** one input beat per cycle sustained when `data_out_ready` is held high. This gives one result every `ACC_DEPTH` cycles, or every cycle when `ACC_DEPTH==1`.
- **No bubbles:** the group boundary inserts no idle cycle. Beat 0 of the next group may be accepted in the cycle immediately after the final beat.
- **Stall recovery:** a stalled final beat is accepted in the same cycle that `data_out_ready` drains the pending result.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `data_in_valid=1` -> `data_out_valid=0`, `data_out=0`, no result emitted. Then deassert -> `data_in_ready=1`.
- **Basic group:** `IN_SIZE=4`, `ACC_DEPTH=2`, `data_out_ready=1`. Beats {1,2,3,4} then {5,6,7,8} on consecutive cycles -> exactly one result, `data_out=36`, valid for 1 cycle, 1 cycle after the second beat.
- **Signed extremes:** `IN_WIDTH=8`, `IN_SIZE=4`, `ACC_DEPTH=4`. Four beats of all -128 -> `data_out=-2048`, correct in `OUT_WIDTH=12` with no wrap. Then four beats of all +127 -> `data_out=2032`.
- **Backpressure:** `ACC_DEPTH=2`, `data_out_ready=0`, feed 4 beats.
  - First result held stable; beat 3 accepted; beat 4 stalls with `data_in_ready=0`.
  - Raise `data_out_ready` -> first result drains in the same cycle beat 4 is accepted.
  - Second result appears next cycle. No data lost or duplicated.
- **Back-to-back:** `ACC_DEPTH=1`, continuous valid inputs {1,1,1,1}, {2,2,2,2}, {-3,0,0,0}, `data_out_ready=1` -> outputs 4, 8, -3 on consecutive cycles.
- **Reset mid-group:** `ACC_DEPTH=4`, accept 2 beats of {10,0,0,0}, pulse `rst`, then feed 4 beats of {1,0,0,0} -> single result `data_out=4`; the pre-reset partial sum does not contribute.
